// File: rtl/register_reader.sv
// rtl/register_reader.sv - 4-phase handshake register read port with programmable wait
//
// Serves one read per 4-phase handshake from a bank of eight 16-bit registers.
// Optional feature macro: REGISTER_READER_PARITY_EN adds the read_parity output.
//
// Parameters:
//   NUM_REGS     number of valid register slots (1..8)
//   WAIT_CYCLES  extra cycles between address capture and response (0..15)
// Ports:
//   clock          rising-edge clock
//   reset          synchronous active-high reset, only honoured when clock_valid=1
//   clock_valid    gates every state update; all state holds when 0
//   reg_values     eight 16-bit registers, slot i at [16i+15:16i]
//   read_command   request level from the initiator
//   read_address   slot index, sampled only when a request is captured
//   read_response  acknowledge level
//   read_data      value snapshotted from the addressed slot
//   read_error     1 when the captured address is >= NUM_REGS
//   read_count     number of completed reads, wraps at 16 bits
//   read_parity    (REGISTER_READER_PARITY_EN only) odd parity over read_data
module register_reader #(
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clock_valid,
  input  logic [127:0] reg_values,
  input  logic         read_command,
  input  logic [2:0]   read_address,
  output logic         read_response,
  output logic [15:0]  read_data,
  output logic         read_error,
  output logic [15:0]  read_count
`ifdef REGISTER_READER_PARITY_EN
  ,
  output logic         read_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [2:0]  captured_address;
  logic [2:0]  next_address;
  logic [3:0]  wait_count;
  logic [3:0]  next_wait;
  logic        response;
  logic        next_response;
  logic [15:0] data;
  logic [15:0] next_data;
  logic        error;
  logic        next_error;
  logic [15:0] count;
  logic [15:0] next_count;

  logic [15:0] slot_value;
  logic        in_range;

  assign slot_value = reg_values[{captured_address, 4'b0000} +: 16];
  assign in_range   = ({1'b0, captured_address} < 4'(NUM_REGS));

  // State register: reset wins over everything, but only on a valid clock.
  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (reset) begin
        state            <= IDLE;
        captured_address <= 3'd0;
        wait_count       <= 4'd0;
        response         <= 1'b0;
        data             <= 16'h0000;
        error            <= 1'b0;
        count            <= 16'h0000;
      end else begin
        state            <= next_state;
        captured_address <= next_address;
        wait_count       <= next_wait;
        response         <= next_response;
        data             <= next_data;
        error            <= next_error;
        count            <= next_count;
      end
    end
  end

  always_comb begin
    next_state    = state;
    next_address  = captured_address;
    next_wait     = wait_count;
    next_response = response;
    next_data     = data;
    next_error    = error;
    next_count    = count;
    case (state)
      IDLE: begin
        // response must have fallen before a new request is accepted
        if (read_command && !response) begin
          next_address = read_address;
          next_wait    = 4'(WAIT_CYCLES);
          next_state   = (WAIT_CYCLES > 0) ? WAIT : RESPOND;
        end
      end
      WAIT: begin
        // leave on the edge where the counter reaches zero; a dropped
        // request does not abort the read
        if (wait_count <= 4'd1) begin
          next_wait  = 4'd0;
          next_state = RESPOND;
        end else begin
          next_wait = wait_count - 4'd1;
        end
      end
      RESPOND: begin
        next_data     = in_range ? slot_value : 16'h0000;
        next_error    = !in_range;
        next_response = 1'b1;
        next_state    = RELEASE;
      end
      RELEASE: begin
        if (!read_command) begin
          next_response = 1'b0;
          next_count    = count + 16'd1;
          next_state    = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign read_response = response;
  assign read_data     = data;
  assign read_error    = error;
  assign read_count    = count;

`ifdef REGISTER_READER_PARITY_EN
  logic parity;

  // Tracks next_data so it changes on the same edge as read_data; the
  // reset value 1 is the odd parity of 0x0000.
  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (reset) begin
        parity <= 1'b1;
      end else begin
        parity <= ~^next_data;
      end
    end
  end

  assign read_parity = parity;
`endif

endmodule

// File: tb/tb_register_reader.sv
// tb/tb_register_reader.sv - directed self-checking bench for register_reader
module tb_register_reader;

  logic         clock = 1'b0;
  logic         reset;
  logic         clock_valid;
  logic [127:0] reg_values;
  logic         read_command;
  logic [2:0]   read_address;
  logic         read_response;
  logic [15:0]  read_data;
  logic         read_error;
  logic [15:0]  read_count;
`ifdef REGISTER_READER_PARITY_EN
  logic         read_parity;
`endif

  int          tests = 0;
  int          failures = 0;
  logic [15:0] exp_count = 16'h0000;

  always #5 clock = ~clock;

  register_reader #(
    .NUM_REGS    (5),
    .WAIT_CYCLES (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .clock_valid   (clock_valid),
    .reg_values    (reg_values),
    .read_command  (read_command),
    .read_address  (read_address),
    .read_response (read_response),
    .read_data     (read_data),
    .read_error    (read_error),
    .read_count    (read_count)
`ifdef REGISTER_READER_PARITY_EN
    ,
    .read_parity   (read_parity)
`endif
  );

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    tests++; if (read_response !== 1'b0) begin failures++; $display("FAIL reset_response got %b want 0", read_response); end
    tests++; if (read_data !== 16'h0000) begin failures++; $display("FAIL reset_data got %h want 0000", read_data); end
    tests++; if (read_error !== 1'b0) begin failures++; $display("FAIL reset_error got %b want 0", read_error); end
    tests++; if (read_count !== 16'h0000) begin failures++; $display("FAIL reset_count got %h want 0000", read_count); end
`ifdef REGISTER_READER_PARITY_EN
    tests++; if (read_parity !== 1'b1) begin failures++; $display("FAIL reset_parity got %b want 1", read_parity); end
`endif
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_basic_read();
    logic exp_resp;
    reg_values[16*3 +: 16] = 16'hBEEF;
    read_address = 3'd3;
    read_command = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      if (i == 1) read_address = 3'd1;
      exp_resp = (i == 4);
      tests++;
      if (read_response !== exp_resp) begin
        failures++; $display("FAIL basic_latency clk%0d got %b want %b", i, read_response, exp_resp);
      end
    end
    tests++; if (read_data !== 16'hBEEF) begin failures++; $display("FAIL basic_data got %h want beef", read_data); end
    tests++; if (read_error !== 1'b0) begin failures++; $display("FAIL basic_error got %b want 0", read_error); end
    step(2);
    tests++; if (read_response !== 1'b1) begin failures++; $display("FAIL basic_hold got %b want 1", read_response); end
    read_command = 1'b0;
    step(1);
    exp_count = exp_count + 16'd1;
    tests++; if (read_response !== 1'b0) begin failures++; $display("FAIL basic_release got %b want 0", read_response); end
    tests++; if (read_count !== exp_count) begin failures++; $display("FAIL basic_count got %h want %h", read_count, exp_count); end
  endtask

  task automatic test_out_of_range();
    logic [2:0]  addrs [3] = '{3'd6, 3'd5, 3'd4};
    logic        errs  [3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] datas [3] = '{16'h0000, 16'h0000, 16'h1004};
    for (int k = 0; k < 3; k++) begin
      read_address = addrs[k];
      read_command = 1'b1;
      step(4);
      tests++; if (read_response !== 1'b1) begin failures++; $display("FAIL range_resp a%0d got %b want 1", addrs[k], read_response); end
      tests++; if (read_data !== datas[k]) begin failures++; $display("FAIL range_data a%0d got %h want %h", addrs[k], read_data, datas[k]); end
      tests++; if (read_error !== errs[k]) begin failures++; $display("FAIL range_error a%0d got %b want %b", addrs[k], read_error, errs[k]); end
      read_command = 1'b0;
      step(1);
      exp_count = exp_count + 16'd1;
      tests++; if (read_count !== exp_count) begin failures++; $display("FAIL range_count a%0d got %h want %h", addrs[k], read_count, exp_count); end
    end
  endtask

  task automatic test_clock_gating();
    logic exp_resp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    reg_values[16*2 +: 16] = 16'h5A5A;
    read_address = 3'd2;
    read_command = 1'b1;
    for (int i = 0; i < 7; i++) begin
      clock_valid = !(i >= 2 && i <= 4);
      step(1);
      tests++;
      if (read_response !== exp_resp[i]) begin
        failures++; $display("FAIL gate_resp clk%0d got %b want %b", i, read_response, exp_resp[i]);
      end
    end
    clock_valid = 1'b1;
    tests++; if (read_data !== 16'h5A5A) begin failures++; $display("FAIL gate_data got %h want 5a5a", read_data); end
    read_command = 1'b0;
    step(1);
    exp_count = exp_count + 16'd1;
    tests++; if (read_count !== exp_count) begin failures++; $display("FAIL gate_count got %h want %h", read_count, exp_count); end
  endtask

  task automatic test_drop_in_wait();
    reg_values[16*1 +: 16] = 16'h0F0F;
    read_address = 3'd1;
    read_command = 1'b1;
    step(1);
    read_command = 1'b0;
    step(2);
    tests++; if (read_response !== 1'b0) begin failures++; $display("FAIL drop_early got %b want 0", read_response); end
    step(1);
    tests++; if (read_response !== 1'b1) begin failures++; $display("FAIL drop_resp got %b want 1", read_response); end
    tests++; if (read_data !== 16'h0F0F) begin failures++; $display("FAIL drop_data got %h want 0f0f", read_data); end
    step(1);
    exp_count = exp_count + 16'd1;
    tests++; if (read_response !== 1'b0) begin failures++; $display("FAIL drop_release got %b want 0", read_response); end
    tests++; if (read_count !== exp_count) begin failures++; $display("FAIL drop_count got %h want %h", read_count, exp_count); end
  endtask

  task automatic test_reset_mid_read();
    reg_values[16*0 +: 16] = 16'h7777;
    read_address = 3'd0;
    read_command = 1'b1;
    step(2);
    reset = 1'b1;
    read_command = 1'b0;
    step(1);
    exp_count = 16'h0000;
    tests++; if (read_response !== 1'b0) begin failures++; $display("FAIL midrst_resp got %b want 0", read_response); end
    tests++; if (read_data !== 16'h0000) begin failures++; $display("FAIL midrst_data got %h want 0000", read_data); end
    tests++; if (read_count !== 16'h0000) begin failures++; $display("FAIL midrst_count got %h want 0000", read_count); end
    reset = 1'b0;
    step(1);
    read_address = 3'd3;
    read_command = 1'b1;
    step(4);
    tests++; if (read_response !== 1'b1) begin failures++; $display("FAIL midrst_next_resp got %b want 1", read_response); end
    tests++; if (read_data !== 16'hBEEF) begin failures++; $display("FAIL midrst_next_data got %h want beef", read_data); end
    read_command = 1'b0;
    step(1);
    exp_count = exp_count + 16'd1;
    tests++; if (read_count !== exp_count) begin failures++; $display("FAIL midrst_next_count got %h want %h", read_count, exp_count); end
  endtask

  task automatic test_wrap_snapshot();
    force dut.count = 16'hFFFF;
    #1;
    release dut.count;
    exp_count = 16'hFFFF;
    tests++; if (read_count !== exp_count) begin failures++; $display("FAIL wrap_preset got %h want ffff", read_count); end
    reg_values[16*0 +: 16] = 16'h1111;
    read_address = 3'd0;
    read_command = 1'b1;
    step(4);
    tests++; if (read_data !== 16'h1111) begin failures++; $display("FAIL snap_data got %h want 1111", read_data); end
    reg_values[16*0 +: 16] = 16'h2222;
    step(2);
    tests++; if (read_data !== 16'h1111) begin failures++; $display("FAIL snap_hold got %h want 1111", read_data); end
    read_command = 1'b0;
    step(1);
    exp_count = exp_count + 16'd1;
    tests++; if (read_count !== exp_count) begin failures++; $display("FAIL wrap_count got %h want %h", read_count, exp_count); end
    tests++; if (read_data !== 16'h1111) begin failures++; $display("FAIL snap_idle got %h want 1111", read_data); end
    read_command = 1'b1;
    step(4);
    tests++; if (read_data !== 16'h2222) begin failures++; $display("FAIL snap_next got %h want 2222", read_data); end
    read_command = 1'b0;
    step(1);
  endtask

`ifdef REGISTER_READER_PARITY_EN
  task automatic test_parity();
    logic [15:0] vals [2] = '{16'h0001, 16'h0003};
    logic        pars [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      reg_values[16*4 +: 16] = vals[k];
      read_address = 3'd4;
      read_command = 1'b1;
      step(4);
      tests++; if (read_parity !== pars[k]) begin failures++; $display("FAIL parity v%h got %b want %b", vals[k], read_parity, pars[k]); end
      read_command = 1'b0;
      step(1);
    end
    reset = 1'b1;
    step(1);
    tests++; if (read_parity !== 1'b1) begin failures++; $display("FAIL parity_reset got %b want 1", read_parity); end
    reset = 1'b0;
    step(1);
  endtask
`endif

  initial begin
    reset        = 1'b1;
    clock_valid  = 1'b1;
    read_command = 1'b0;
    read_address = 3'd0;
    for (int s = 0; s < 8; s++) reg_values[16*s +: 16] = 16'h1000 + 16'(s);
    @(negedge clock);
    test_reset();
    test_basic_read();
    test_out_of_range();
    test_clock_gating();
    test_drop_in_wait();
    test_reset_mid_read();
    test_wrap_snapshot();
`ifdef REGISTER_READER_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/register_reader.md
REGISTER_READER -- requirements
Module: register_reader

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, number of valid register slots (1..8).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra cycles between address capture and response (0..15).
REQ-003 SHALL have port clock, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port clock_valid, input, 1, gates every state update; when 0, all state holds.
REQ-006 SHALL have port reg_values, input, 128, eight 16-bit register outputs; slot i occupies bits [16i+15:16i].
REQ-007 SHALL have port read_command, input, 1, 4-phase request level from the initiator.
REQ-008 SHALL have port read_address, input, 3, slot index; sampled only at request capture.
REQ-009 SHALL have port read_response, output, 1, 4-phase acknowledge level.
REQ-010 SHALL have port read_data, output, 16, returned register value.
REQ-011 SHALL have port read_error, output, 1, 1 when the captured address is >= NUM_REGS.
REQ-012 SHALL have port read_count, output, 16, number of completed reads.

Function
REQ-013 SHALL implement the states IDLE, WAIT, RESPOND and RELEASE.
REQ-014 IDLE: when read_command=1 and read_response=0, SHALL capture read_address and load the wait counter with WAIT_CYCLES.
  - WAIT_CYCLES>0: next state WAIT.
  - WAIT_CYCLES=0: next state RESPOND.
REQ-015 WAIT: SHALL decrement the counter each valid cycle and go to RESPOND on the cycle the counter reaches 0.
REQ-016 RESPOND: SHALL sample the captured slot of reg_values into read_data (0 if out of range), set read_error, set read_response=1, and go to RELEASE.
REQ-017 read_data SHALL reflect reg_values at the RESPOND cycle; later changes SHALL NOT affect it until the next read.
REQ-018 RELEASE: read_response SHALL stay 1 until read_command=0.
  - On that cycle: read_response<=0, read_count increments (wraps 0xFFFF->0x0000), next state IDLE.
REQ-019 Latency from read_command rising to read_response rising SHALL be WAIT_CYCLES+2 valid clocks.
REQ-020 If read_command drops during WAIT, the read SHALL still complete to RESPOND; RELEASE then exits on the next valid cycle.
REQ-021 read_data and read_error SHALL hold their last values in IDLE and WAIT.
REQ-022 read_address changes after capture SHALL be ignored.
REQ-023 When clock_valid=0, the FSM, counter, outputs and read_count SHALL hold, including during WAIT.

Reset
REQ-024 Reset SHALL act only on a clock edge with clock_valid=1 and SHALL take priority over every other update.
REQ-025 Reset SHALL force: state IDLE, read_response=0, read_data=0x0000, read_error=0, read_count=0x0000, wait counter=0.
REQ-026 Reset in any state SHALL abort the transaction without incrementing read_count.

Configuration
REQ-027 Macro REGISTER_READER_PARITY_EN SHALL gate an optional parity output.
  - When defined: add output read_parity, 1, odd parity over read_data. It SHALL update in the same cycle as read_data and reset to 1.
  - When undefined: the port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Basic read: reset; slot3=0xBEEF; address=3, command=1 -> response=1 after 4 valid clocks, read_data=0xBEEF, error=0; command=0 -> response=0, read_count=1.
REQ-029 Out of range: NUM_REGS=5, address=6 -> read_data=0x0000, read_error=1, response handshake completes, read_count increments.
REQ-030 Clock gating: WAIT_CYCLES=2, clock_valid=0 for 3 cycles mid-WAIT -> response delayed by exactly 3 clocks; data correct.
REQ-031 Reset mid-read: reset asserted in WAIT -> next cycle response=0, read_data=0, read_count=0; next request serves normally.
REQ-032 Wrap and snapshot: preset count to 0xFFFF via 65535 reads (or force); slot0 changes 0x1111->0x2222 after RESPOND -> read_data stays 0x1111; count wraps to 0x0000.
REQ-033 Parity (macro defined): read 0x0001 -> read_parity=0; read 0x0003 -> read_parity=1; after reset read_parity=1.
